// File: rtl/sr_drv_pkg.sv
// Shared types and constants for the SR flip-flop bank driver.
// Excitation codes are packed as {S,R}; 2'b11 is illegal and never produced.
package sr_drv_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StSettle,
    StCheck
  } drv_state_e;

  localparam logic [1:0] EXC_HOLD = 2'b00;
  localparam logic [1:0] EXC_SET  = 2'b10;
  localparam logic [1:0] EXC_RST  = 2'b01;

endpackage

// File: rtl/sr_excite.sv
// Single-bit excitation map: the {S,R} code that moves q toward target.
module sr_excite
  import sr_drv_pkg::*;
(
  input  logic       target_i,
  input  logic       q_i,
  output logic [1:0] exc_o
);

  always_comb begin
    exc_o = EXC_HOLD;
    if (target_i && !q_i) begin
      exc_o = EXC_SET;
    end else if (!target_i && q_i) begin
      exc_o = EXC_RST;
    end
  end

endmodule

// File: rtl/sr_ff_bank_driver.sv
// Drives a bank of SR flip-flops to a target word, verifies the readback and retries
// a bounded number of times before reporting an error.
module sr_ff_bank_driver
  import sr_drv_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned SETTLE    = 1,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  output logic [WIDTH-1:0]               S,
  output logic [WIDTH-1:0]               R,
  input  logic [WIDTH-1:0]               Q,
  output logic                           done,
  output logic                           err,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
);

  localparam int unsigned RcW  = $clog2(MAX_RETRY + 1);
  localparam int unsigned SetW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  drv_state_e        state_q, state_d;
  logic [WIDTH-1:0]  target_q, target_d;
  logic [SetW-1:0]   settle_q, settle_d;
  logic [RcW-1:0]    retry_q, retry_d;
  logic [WIDTH-1:0]  s_q, s_d, r_q, r_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [WIDTH-1:0]  exc_tgt;
  logic [WIDTH-1:0]  exc_s, exc_r;
  logic [1:0]        exc [WIDTH];

  // Fresh word on accept, latched target on re-drive.
  assign exc_tgt = (state_q == StIdle) ? in_data : target_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_excite
    sr_excite u_excite (
      .target_i (exc_tgt[i]),
      .q_i      (Q[i]),
      .exc_o    (exc[i])
    );
    assign exc_s[i] = exc[i][1];
    assign exc_r[i] = exc[i][0];
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    settle_d = settle_q;
    retry_d  = retry_q;
    s_d      = '0;
    r_d      = '0;
    done_d   = 1'b0;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          target_d = in_data;
          retry_d  = '0;
          err_d    = 1'b0;
          s_d      = exc_s;
          r_d      = exc_r;
          state_d  = StDrive;
        end
      end
      StDrive: begin
        settle_d = SetW'(SETTLE - 1);
        state_d  = StSettle;
      end
      StSettle: begin
        if (settle_q == '0) begin
          state_d = StCheck;
        end else begin
          settle_d = settle_q - SetW'(1);
        end
      end
      StCheck: begin
        if (Q == target_q) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (retry_q < RcW'(MAX_RETRY)) begin
          retry_d = retry_q + RcW'(1);
          s_d     = exc_s;
          r_d     = exc_r;
          state_d = StDrive;
        end else begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      target_q <= '0;
      settle_q <= '0;
      retry_q  <= '0;
      s_q      <= '0;
      r_q      <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      settle_q <= settle_d;
      retry_q  <= retry_d;
      s_q      <= s_d;
      r_q      <= r_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign S         = s_q;
  assign R         = r_q;
  assign done      = done_q;
  assign err       = err_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_sr_ff_bank_driver.sv
// Bench for sr_ff_bank_driver: SR bank model with a stuck-at-0 mask, a transaction-level
// reference checked every cycle, directed scenarios and a randomized phase.
module tb_sr_ff_bank_driver;

  localparam int W         = 4;
  localparam int SETTLE    = 1;
  localparam int MAX_RETRY = 3;
  localparam int PERIOD    = SETTLE + 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic [W-1:0] S, R, Q;
  logic         done, err;
  logic [1:0]   retry_cnt;

  logic [W-1:0] bank_q;
  logic         bank_rst = 1'b1;
  logic [W-1:0] stuck = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sr_ff_bank_driver #(
    .WIDTH     (W),
    .SETTLE    (SETTLE),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .S         (S),
    .R         (R),
    .Q         (Q),
    .done      (done),
    .err       (err),
    .retry_cnt (retry_cnt)
  );

  // Synchronous-reset SR cells; stuck bits read back as 0.
  always @(posedge clk) begin
    for (int i = 0; i < W; i++) begin
      if (bank_rst)  bank_q[i] <= 1'b0;
      else if (S[i]) bank_q[i] <= 1'b1;
      else if (R[i]) bank_q[i] <= 1'b0;
    end
  end
  assign Q = bank_q & ~stuck;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Transaction-level reference: an operation is a series of attempts, each PERIOD cycles
  // long, decided on the edge that closes it.
  logic         m_busy = 1'b0;
  int           m_off = 0;
  logic [W-1:0] m_tgt = '0;
  logic [W-1:0] m_s = '0, m_r = '0;
  logic         m_done = 1'b0, m_err = 1'b0;
  int           m_rc = 0;

  initial begin
    forever begin
      @(posedge clk);
      m_s = '0;
      m_r = '0;
      m_done = 1'b0;
      if (rst) begin
        m_busy = 1'b0; m_off = 0; m_err = 1'b0; m_rc = 0;
      end else if (!m_busy) begin
        if (in_valid) begin
          m_busy = 1'b1; m_off = 0; m_tgt = in_data; m_err = 1'b0; m_rc = 0;
          m_s = m_tgt & ~Q;
          m_r = ~m_tgt & Q;
        end
      end else begin
        m_off++;
        if (m_off == PERIOD) begin
          m_off = 0;
          if (Q == m_tgt) begin
            m_done = 1'b1; m_busy = 1'b0;
          end else if (m_rc < MAX_RETRY) begin
            m_rc++;
            m_s = m_tgt & ~Q;
            m_r = ~m_tgt & Q;
          end else begin
            m_done = 1'b1; m_err = 1'b1; m_busy = 1'b0;
          end
        end
      end
    end
  end

  // Per-cycle compare against the reference; reset forces the quiescent expectation.
  always @(negedge clk) begin
    checks++;
    if ((S & R) != '0) begin
      failures++;
      $display("FAIL s_and_r_excl S=%b R=%b t=%0t", S, R, $time);
    end
    if (rst) begin
      chk("rst_outputs", {S, R, in_ready, done, err, retry_cnt},
          {{W{1'b0}}, {W{1'b0}}, 1'b1, 1'b0, 1'b0, 2'd0});
    end else begin
      chk("model_outputs", {S, R, in_ready, done, err, retry_cnt},
          {m_s, m_r, ~m_busy, m_done, m_err, 2'(m_rc)});
    end
  end

  // Starts just after a negedge; returns latency (cycles from accept edge to done) and
  // number of cycles with any excitation asserted.
  task automatic send(input logic [W-1:0] w, output int lat, output int drives,
                      output logic [W-1:0] s0, output logic [W-1:0] r0);
    int n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    in_valid = 1'b0;
    s0 = S;
    r0 = R;
    lat = 1;
    drives = 0;
    while (!done && lat < 60) begin
      if ((S | R) != '0) drives++;
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout got=0 expected=1 word=%b", w);
    end
  endtask

  int lat, drives;
  logic [W-1:0] s0, r0;

  initial begin
    // 1. reset
    repeat (5) @(negedge clk);
    chk("reset_S", S, 0);
    chk("reset_R", R, 0);
    chk("reset_ready_done_err_rc", {in_ready, done, err, retry_cnt}, 5'b10000);
    rst = 1'b0;
    bank_rst = 1'b0;
    @(negedge clk);

    // 2. 0000 -> 1010
    send(4'b1010, lat, drives, s0, r0);
    chk("t2_S", s0, 4'b1010);
    chk("t2_R", r0, 4'b0000);
    chk("t2_latency", lat, 4);
    chk("t2_ready_with_done", in_ready, 1);
    chk("t2_err", err, 0);
    chk("t2_Q", Q, 4'b1010);

    // 3. 1010 -> 0110, bit1 held
    send(4'b0110, lat, drives, s0, r0);
    chk("t3_S", s0, 4'b0100);
    chk("t3_R", r0, 4'b1000);
    chk("t3_err", err, 0);
    chk("t3_Q", Q, 4'b0110);

    // 4. bit0 stuck at 0: four failing attempts
    stuck = 4'b0001;
    send(4'b0001, lat, drives, s0, r0);
    chk("t4_S_first", s0, 4'b0001);
    chk("t4_R_first", r0, 4'b0110);
    chk("t4_drive_cycles", drives, 4);
    chk("t4_latency", lat, 13);
    chk("t4_err", err, 1);
    chk("t4_retry_cnt", retry_cnt, 3);
    @(negedge clk);
    chk("t4_done_single_pulse", done, 0);
    chk("t4_err_holds", {err, retry_cnt}, 3'b111);
    stuck = '0;

    // 5. 0001 -> 1000 with 1111 offered while busy
    in_valid = 1'b1;
    in_data  = 4'b1000;
    @(negedge clk);              // DRIVE
    in_data = 4'b1111;
    @(negedge clk);              // SETTLE
    chk("t5_ready_settle", in_ready, 0);
    @(negedge clk);              // CHECK
    chk("t5_ready_check", in_ready, 0);
    in_valid = 1'b0;
    @(negedge clk);              // done
    chk("t5_done", done, 1);
    chk("t5_Q", Q, 4'b1000);
    @(negedge clk);
    chk("t5_no_second_op", in_ready, 1);

    // 6. reset asserted in DRIVE
    in_valid = 1'b1;
    in_data  = 4'b0011;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("t6_S_in_drive", S, 4'b0011);
    rst = 1'b1;
    #1;
    chk("t6_async_SR", {S, R}, 8'h00);
    chk("t6_async_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t6_no_done", done, 0);
    end
    chk("t6_ready_after", in_ready, 1);
    chk("t6_Q_untouched", Q, 4'b1000);

    // Random phase: busy-time valids, occasional stuck bits, back-to-back offers.
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = W'($urandom);
      if ($urandom_range(0, 9) == 0)
        stuck = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
    end
    in_valid = 1'b0;
    stuck = '0;
    begin
      int n = 0;
      while (!in_ready && n < 40) begin @(negedge clk); n++; end
    end
    @(negedge clk);
    chk("final_idle", in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
